// File: rtl/loader_pkg.sv
// +----------------------------------------------------------------------+
// | loader_pkg : shared constants, state encodings and sizing helpers     |
// |              for the UART instruction-memory loader                   |
// | Revision   : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

package loader_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   localparam int unsigned DEF_CLK_HZ  = 100_000_000;
   localparam int unsigned DEF_BAUD    = 115200;
   localparam int unsigned DEF_TO_BITS = 64;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_HI = 3'd1,
      ST_LEN_LO = 3'd2,
      ST_DATA   = 3'd3,
      ST_DONE   = 3'd4
   } ld_state_e;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

   function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
      return clk_hz / baud;
   endfunction

   function automatic int unsigned to_width(input int unsigned div, input int unsigned to_bits);
      return $clog2(div * to_bits + 1);
   endfunction

   localparam int unsigned DIV  = calc_div(DEF_CLK_HZ, DEF_BAUD);
   localparam int unsigned TO_W = to_width(DIV, DEF_TO_BITS);

endpackage

`default_nettype wire

// File: rtl/imem_uart_loader_rx.sv
// +----------------------------------------------------------------------+
// | uart_rx_core : 2-FF synchronizer, bit timer and 8N1 deframer          |
// |                producing one-cycle byte / framing-error pulses        |
// | Revision     : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_rx_core
   import loader_pkg::*;
#(
   parameter int unsigned DIV = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   output logic       byte_valid_o,
   output logic [7:0] byte_data_o,
   output logic       frame_err_o,
   output logic       busy_o
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic          meta_q, sync_q, prev_q;
   rx_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sh_q, sh_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;

   logic w_fall, w_tick_half, w_tick_full;

   assign w_fall      = prev_q & ~sync_q;
   assign w_tick_half = (cnt_q == CW'(DIV / 2 - 1));
   assign w_tick_full = (cnt_q == CW'(DIV - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q  <= 1'b0;
         sync_q  <= 1'b0;
         prev_q  <= 1'b0;
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         meta_q  <= rx_i;
         sync_q  <= meta_q;
         prev_q  <= sync_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      sh_d    = sh_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            if (w_fall) state_d = RX_START;
         end
         RX_START: begin
            // Mid-start-bit re-check rejects short low glitches
            if (w_tick_half) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = sync_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (w_tick_full) begin
               cnt_d = '0;
               sh_d  = {sync_q, sh_q[7:1]};
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (w_tick_full) begin
               cnt_d   = '0;
               state_d = RX_IDLE;
               if (sync_q) begin
                  valid_d = 1'b1;
                  data_d  = sh_q;
               end else begin
                  ferr_d  = 1'b1;
               end
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   assign byte_valid_o = valid_q;
   assign byte_data_o  = data_q;
   assign frame_err_o  = ferr_q;
   assign busy_o       = (state_q != RX_IDLE);

endmodule

`default_nettype wire

// File: rtl/imem_uart_loader.sv
// +----------------------------------------------------------------------+
// | imem_uart_loader : UART program loader writing 32-bit words into the  |
// |                    IMem write port while holding the CPU in reset     |
// | Revision         : 1.0  initial release                               |
// +----------------------------------------------------------------------+
`default_nettype none

module imem_uart_loader
   import loader_pkg::*;
#(
   parameter int unsigned CLK_HZ  = DEF_CLK_HZ,
   parameter int unsigned BAUD    = DEF_BAUD,
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned TO_BITS = DEF_TO_BITS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx,
   input  logic              en,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err
);

   localparam int unsigned CLK_DIV = calc_div(CLK_HZ, BAUD);
   localparam int unsigned TO_LIM  = TO_BITS * CLK_DIV;
   localparam int unsigned TO_CW   = to_width(CLK_DIV, TO_BITS);
   localparam logic [16:0] CAP     = 17'd1 << ADDR_W;

   logic       w_byte_valid, w_frame_err, w_rx_busy;
   logic [7:0] w_byte_data;

   uart_rx_core #(
      .DIV (CLK_DIV)
   ) u_rx (
      .clk          (clk),
      .rst          (rst),
      .rx_i         (rx),
      .byte_valid_o (w_byte_valid),
      .byte_data_o  (w_byte_data),
      .frame_err_o  (w_frame_err),
      .busy_o       (w_rx_busy)
   );

   ld_state_e          state_q, state_d;
   logic [15:0]        len_q, len_d;
   logic [31:0]        word_q, word_d;
   logic [1:0]         byte_idx_q, byte_idx_d;
   logic [ADDR_W-1:0]  word_idx_q, word_idx_d;
   logic [TO_CW-1:0]   to_cnt_q, to_cnt_d;
   logic               we_q, we_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic               hold_q, hold_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic        w_abort, w_timeout;
   logic [15:0] w_n;
   logic [31:0] w_word;

   assign w_n       = {len_q[7:0], w_byte_data};
   assign w_word    = {word_q[23:0], w_byte_data};
   assign w_timeout = (to_cnt_q == TO_CW'(TO_LIM - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         len_q      <= '0;
         word_q     <= '0;
         byte_idx_q <= '0;
         word_idx_q <= '0;
         to_cnt_q   <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         hold_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         word_q     <= word_d;
         byte_idx_q <= byte_idx_d;
         word_idx_q <= word_idx_d;
         to_cnt_q   <= to_cnt_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         hold_q     <= hold_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      word_d     = word_q;
      byte_idx_d = byte_idx_q;
      word_idx_d = word_idx_q;
      to_cnt_d   = to_cnt_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      hold_d     = hold_q;
      done_d     = 1'b0;
      err_d      = err_q;
      w_abort    = 1'b0;

      // Timeout measures line silence: a character in flight also reloads it
      if (w_byte_valid || w_rx_busy) begin
         to_cnt_d = '0;
      end else if (!w_timeout) begin
         to_cnt_d = to_cnt_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            to_cnt_d = '0;
            if (en && w_byte_valid && (w_byte_data == SYNC_BYTE)) begin
               state_d = ST_LEN_HI;
               hold_d  = 1'b1;
               err_d   = 1'b0;
            end
         end
         ST_LEN_HI, ST_LEN_LO, ST_DATA: begin
            if (!en || w_frame_err) begin
               w_abort = 1'b1;
            end else if (w_byte_valid) begin
               if (state_q == ST_LEN_HI) begin
                  len_d   = {8'h00, w_byte_data};
                  state_d = ST_LEN_LO;
               end else if (state_q == ST_LEN_LO) begin
                  if ((w_n == 16'd0) || ({1'b0, w_n} > CAP)) begin
                     w_abort = 1'b1;
                  end else begin
                     len_d      = w_n;
                     word_idx_d = '0;
                     byte_idx_d = '0;
                     state_d    = ST_DATA;
                  end
               end else begin
                  word_d     = w_word;
                  byte_idx_d = byte_idx_q + 2'd1;
                  if (byte_idx_q == 2'd3) begin
                     we_d       = 1'b1;
                     addr_d     = word_idx_q;
                     wdata_d    = w_word;
                     word_idx_d = word_idx_q + 1'b1;
                     if (16'(word_idx_q) == (len_q - 16'd1)) state_d = ST_DONE;
                  end
               end
            end else if (w_timeout) begin
               w_abort = 1'b1;
            end
         end
         ST_DONE: begin
            to_cnt_d = '0;
            done_d   = 1'b1;
            hold_d   = 1'b0;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (w_abort) begin
         err_d    = 1'b1;
         hold_d   = 1'b0;
         to_cnt_d = '0;
         state_d  = ST_IDLE;
      end
   end

   assign im_we     = we_q;
   assign im_addr   = addr_q;
   assign im_wdata  = wdata_q;
   assign cpu_hold  = hold_q;
   assign load_done = done_q;
   assign load_err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_uart_loader.sv
// +----------------------------------------------------------------------+
// | tb_imem_uart_loader : self-checking bench for imem_uart_loader        |
// |                       (DIV=16, 16-word IMem, 4-bit-time timeout)      |
// | Revision            : 1.0  initial release                            |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_imem_uart_loader;

   localparam int unsigned CLK_HZ  = 16;
   localparam int unsigned BAUD    = 1;
   localparam int unsigned ADDR_W  = 4;
   localparam int unsigned TO_BITS = 4;
   localparam int          DIV     = 16;
   localparam logic [7:0]  SYNC    = 8'hA5;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              rx  = 1'b1;
   logic              en  = 1'b1;
   logic              im_we;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_wdata;
   logic              cpu_hold, load_done, load_err;

   int          total = 0;
   int          bad   = 0;
   logic [35:0] got[$];
   int          done_cnt  = 0;
   int          hold_viol = 0;
   logic        prev_hold = 1'b0;

   logic [35:0] exp_q[$];
   int          m_done;
   logic        m_err;

   imem_uart_loader #(
      .CLK_HZ  (CLK_HZ),
      .BAUD    (BAUD),
      .ADDR_W  (ADDR_W),
      .TO_BITS (TO_BITS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .en        (en),
      .im_we     (im_we),
      .im_addr   (im_addr),
      .im_wdata  (im_wdata),
      .cpu_hold  (cpu_hold),
      .load_done (load_done),
      .load_err  (load_err)
   );

   always #5 clk = ~clk;

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
      $fatal(1, "watchdog");
   end

   // Write/done recorder; cpu_hold must fall exactly when load_done is high
   always @(negedge clk) begin
      if (im_we) got.push_back({im_addr, im_wdata});
      if (load_done) begin
         done_cnt++;
         if (!(prev_hold && !cpu_hold)) hold_viol++;
      end
      prev_hold = cpu_hold;
   end

   task automatic clear_mon();
      got.delete();
      done_cnt  = 0;
      hold_viol = 0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         rx = b[k];
         repeat (DIV) @(negedge clk);
      end
      rx = stop;
      repeat (DIV) @(negedge clk);
      rx = 1'b1;
      if (!stop) repeat (2 * DIV) @(negedge clk);
   endtask

   task automatic send_stream(input logic [7:0] q[$], input int maxgap);
      for (int i = 0; i < q.size(); i++) begin
         send_byte(q[i], 1'b1);
         repeat ($urandom_range(0, maxgap)) @(negedge clk);
      end
      repeat (120) @(negedge clk);
   endtask

   // Frame-level reference: scan for sync, read big-endian N, group data in fours
   function automatic void model(input logic [7:0] q[$]);
      int i = 0;
      int n, avail, nw;
      exp_q.delete();
      m_done = 0;
      while (i < q.size()) begin
         if (q[i] != SYNC) begin
            i++;
            continue;
         end
         m_err = 1'b0;
         i++;
         if (q.size() - i < 2) begin
            m_err = 1'b1;
            break;
         end
         n = int'({q[i], q[i+1]});
         i += 2;
         if (n == 0 || n > (1 << ADDR_W)) begin
            m_err = 1'b1;
            continue;
         end
         avail = q.size() - i;
         nw = (avail >= 4 * n) ? n : avail / 4;
         for (int w = 0; w < nw; w++)
            exp_q.push_back({4'(w), q[i+4*w], q[i+4*w+1], q[i+4*w+2], q[i+4*w+3]});
         if (avail >= 4 * n) begin
            i += 4 * n;
            m_done++;
         end else begin
            m_err = 1'b1;
            break;
         end
      end
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (4) @(negedge clk);
      total++;
      if ({im_we, im_addr, im_wdata, cpu_hold, load_done, load_err} !== '0) begin
         $display("FAIL reset_outputs: got we=%b addr=%h data=%h hold=%b done=%b err=%b want all 0",
                  im_we, im_addr, im_wdata, cpu_hold, load_done, load_err);
         bad++;
      end
      rst = 1'b0;
      repeat (8) @(negedge clk);
      total++;
      if ({im_we, cpu_hold, load_done, load_err} !== 4'b0) begin
         $display("FAIL idle_after_reset: got we=%b hold=%b done=%b err=%b want 0",
                  im_we, cpu_hold, load_done, load_err);
         bad++;
      end
   endtask

   task automatic test_basic_load();
      logic [7:0] q[$] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      clear_mon();
      send_byte(SYNC, 1'b1);
      total++;
      if (cpu_hold !== 1'b1) begin
         $display("FAIL basic_hold_after_sync: got %b want 1", cpu_hold);
         bad++;
      end
      send_stream(q, 10);
      total++;
      if (got.size() !== 2) begin
         $display("FAIL basic_write_count: got %0d want 2", got.size());
         bad++;
      end else begin
         total++;
         if (got[0] !== {4'd0, 32'h12345678}) begin
            $display("FAIL basic_word0: got %h want %h", got[0], {4'd0, 32'h12345678});
            bad++;
         end
         total++;
         if (got[1] !== {4'd1, 32'hDEADBEEF}) begin
            $display("FAIL basic_word1: got %h want %h", got[1], {4'd1, 32'hDEADBEEF});
            bad++;
         end
      end
      total++;
      if (done_cnt !== 1 || hold_viol !== 0) begin
         $display("FAIL basic_done: got done=%0d hold_viol=%0d want 1/0", done_cnt, hold_viol);
         bad++;
      end
      total++;
      if ({cpu_hold, load_err} !== 2'b00) begin
         $display("FAIL basic_final: got hold=%b err=%b want 0/0", cpu_hold, load_err);
         bad++;
      end
   endtask

   task automatic test_presync();
      logic [7:0] q[$] = '{SYNC, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h2A};
      clear_mon();
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      total++;
      if (cpu_hold !== 1'b0) begin
         $display("FAIL presync_no_hold: got %b want 0", cpu_hold);
         bad++;
      end
      send_stream(q, 0);
      total++;
      if (got.size() !== 1) begin
         $display("FAIL presync_write_count: got %0d want 1", got.size());
         bad++;
      end else begin
         total++;
         if (got[0] !== {4'd0, 32'h0000002A}) begin
            $display("FAIL presync_word0: got %h want %h", got[0], {4'd0, 32'h0000002A});
            bad++;
         end
      end
      total++;
      if (done_cnt !== 1 || load_err !== 1'b0) begin
         $display("FAIL presync_done: got done=%0d err=%b want 1/0", done_cnt, load_err);
         bad++;
      end
   endtask

   task automatic test_bad_length();
      logic [7:0] q[$] = '{SYNC, 8'h00, 8'h11};
      clear_mon();
      send_stream(q, 0);
      total++;
      if ({load_err, cpu_hold} !== 2'b10 || got.size() !== 0 || done_cnt !== 0) begin
         $display("FAIL len17: got err=%b hold=%b writes=%0d done=%0d want 1/0/0/0",
                  load_err, cpu_hold, got.size(), done_cnt);
         bad++;
      end
      send_byte(SYNC, 1'b1);
      total++;
      if ({load_err, cpu_hold} !== 2'b01) begin
         $display("FAIL sync_clears_err: got err=%b hold=%b want 0/1", load_err, cpu_hold);
         bad++;
      end
      repeat (120) @(negedge clk);
      total++;
      if ({load_err, cpu_hold} !== 2'b10) begin
         $display("FAIL len_timeout: got err=%b hold=%b want 1/0", load_err, cpu_hold);
         bad++;
      end
   endtask

   task automatic test_timeout();
      logic [7:0] q[$] = '{SYNC, 8'h00, 8'h02, 8'hC0, 8'hFF, 8'hEE, 8'h01};
      clear_mon();
      for (int i = 0; i < q.size(); i++) send_byte(q[i], 1'b1);
      send_byte(8'h77, 1'b1);
      repeat (40) @(negedge clk);
      total++;
      if ({load_err, cpu_hold} !== 2'b01) begin
         $display("FAIL timeout_not_yet: got err=%b hold=%b want 0/1", load_err, cpu_hold);
         bad++;
      end
      repeat (60) @(negedge clk);
      total++;
      if ({load_err, cpu_hold} !== 2'b10) begin
         $display("FAIL timeout_abort: got err=%b hold=%b want 1/0", load_err, cpu_hold);
         bad++;
      end
      total++;
      if (got.size() !== 1 || done_cnt !== 0) begin
         $display("FAIL timeout_writes: got writes=%0d done=%0d want 1/0", got.size(), done_cnt);
         bad++;
      end else begin
         total++;
         if (got[0] !== {4'd0, 32'hC0FFEE01}) begin
            $display("FAIL timeout_word0: got %h want %h", got[0], {4'd0, 32'hC0FFEE01});
            bad++;
         end
      end
   endtask

   task automatic test_framing_and_glitch();
      logic [7:0] q[$] = '{SYNC, 8'h00, 8'h01, 8'h11};
      clear_mon();
      for (int i = 0; i < q.size(); i++) send_byte(q[i], 1'b1);
      send_byte(8'h22, 1'b0);
      total++;
      if ({load_err, cpu_hold} !== 2'b10) begin
         $display("FAIL framing_abort: got err=%b hold=%b want 1/0", load_err, cpu_hold);
         bad++;
      end
      send_byte(8'h33, 1'b1);
      send_byte(8'h44, 1'b1);
      repeat (40) @(negedge clk);
      total++;
      if (got.size() !== 0) begin
         $display("FAIL framing_no_write: got %0d writes want 0", got.size());
         bad++;
      end
      // Short low pulses inside a data word must not become bytes
      clear_mon();
      send_byte(SYNC, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'hAB, 1'b1);
      send_byte(8'hCD, 1'b1);
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      send_byte(8'hEF, 1'b1);
      send_byte(8'h12, 1'b1);
      repeat (40) @(negedge clk);
      total++;
      if (got.size() !== 1 || done_cnt !== 1) begin
         $display("FAIL glitch_count: got writes=%0d done=%0d want 1/1", got.size(), done_cnt);
         bad++;
      end else begin
         total++;
         if (got[0] !== {4'd0, 32'hABCDEF12}) begin
            $display("FAIL glitch_word: got %h want %h", got[0], {4'd0, 32'hABCDEF12});
            bad++;
         end
      end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] q[$] = '{SYNC, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33};
      clear_mon();
      for (int i = 0; i < q.size(); i++) send_byte(q[i], 1'b1);
      total++;
      if (cpu_hold !== 1'b1) begin
         $display("FAIL midframe_hold: got %b want 1", cpu_hold);
         bad++;
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({im_we, im_addr, im_wdata, cpu_hold, load_done, load_err} !== '0) begin
         $display("FAIL midframe_reset_outputs: got we=%b addr=%h data=%h hold=%b done=%b err=%b want all 0",
                  im_we, im_addr, im_wdata, cpu_hold, load_done, load_err);
         bad++;
      end
      rst = 1'b0;
      repeat (4) @(negedge clk);
      send_byte(8'h44, 1'b1);
      repeat (40) @(negedge clk);
      total++;
      if (got.size() !== 0 || {cpu_hold, load_err} !== 2'b00) begin
         $display("FAIL midframe_after_reset: got writes=%0d hold=%b err=%b want 0/0/0",
                  got.size(), cpu_hold, load_err);
         bad++;
      end
   endtask

   task automatic test_en_drop();
      logic [7:0] q[$] = '{SYNC, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33};
      clear_mon();
      en = 1'b0;
      send_byte(SYNC, 1'b1);
      repeat (4) @(negedge clk);
      total++;
      if ({cpu_hold, load_err} !== 2'b00) begin
         $display("FAIL en_low_idle: got hold=%b err=%b want 0/0", cpu_hold, load_err);
         bad++;
      end
      en = 1'b1;
      for (int i = 0; i < q.size(); i++) send_byte(q[i], 1'b1);
      en = 1'b0;
      repeat (5) @(negedge clk);
      total++;
      if ({load_err, cpu_hold} !== 2'b10) begin
         $display("FAIL en_drop_abort: got err=%b hold=%b want 1/0", load_err, cpu_hold);
         bad++;
      end
      en = 1'b1;
      send_byte(8'h44, 1'b1);
      repeat (40) @(negedge clk);
      total++;
      if (got.size() !== 0 || done_cnt !== 0) begin
         $display("FAIL en_drop_writes: got writes=%0d done=%0d want 0/0", got.size(), done_cnt);
         bad++;
      end
   endtask

   task automatic test_random();
      logic [7:0] q[$];
      int kind, n, nb;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      m_err = 1'b0;
      for (int it = 0; it < 6; it++) begin
         q.delete();
         repeat ($urandom_range(0, 2)) q.push_back(8'($urandom_range(0, 255)));
         kind = $urandom_range(0, 3);
         if (kind == 1) n = ($urandom_range(0, 1) == 1) ? 17 : 0;
         else           n = $urandom_range(1, 3);
         q.push_back(SYNC);
         q.push_back(8'(n >> 8));
         q.push_back(8'(n));
         if (kind == 1)      nb = 0;
         else if (kind == 2) nb = $urandom_range(0, 4 * n - 1);
         else                nb = 4 * n;
         for (int b = 0; b < nb; b++) q.push_back(8'($urandom_range(0, 255)));
         if ($urandom_range(0, 3) == 0) q.push_back(8'($urandom_range(0, 255)));
         model(q);
         clear_mon();
         send_stream(q, 30);
         total++;
         if (got.size() !== exp_q.size()) begin
            $display("FAIL rand%0d_write_count: got %0d want %0d", it, got.size(), exp_q.size());
            bad++;
         end else begin
            for (int w = 0; w < exp_q.size(); w++) begin
               total++;
               if (got[w] !== exp_q[w]) begin
                  $display("FAIL rand%0d_word%0d: got %h want %h", it, w, got[w], exp_q[w]);
                  bad++;
               end
            end
         end
         total++;
         if (done_cnt !== m_done || load_err !== m_err || cpu_hold !== 1'b0 || hold_viol !== 0) begin
            $display("FAIL rand%0d_status: got done=%0d err=%b hold=%b hv=%0d want %0d/%b/0/0",
                     it, done_cnt, load_err, cpu_hold, hold_viol, m_done, m_err);
            bad++;
         end
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      test_reset();
      test_basic_load();
      test_presync();
      test_bad_length();
      test_timeout();
      test_framing_and_glitch();
      test_reset_midframe();
      test_en_drop();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
